serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. Sequences a single full_adder cell over two WIDTH-bit operands, LSB first, with one bit per clock.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake.
- Gives multi-bit addition from one full-adder slice where area matters more than latency.

---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for serial_add_ctrl; master drives requests, slave is the adder.
// Optional sub port is present only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, ci, sub, input busy, done, sum, co);
  modport slave  (input start, a, b, ci, sub, output busy, done, sum, co);
`else
  modport master (output start, a, b, ci, input busy, done, sum, co);
  modport slave  (input start, a, b, ci, output busy, done, sum, co);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice, LSB first, result published WIDTH cycles after start; start ignored while busy.
// Define SERIAL_ADD_SUB_EN to add a sub input that computes a - b (co=1 means no borrow).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             co_q;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // The single full-adder slice shared by every bit position.
  always_comb begin
    bit_s = op_a[0] ^ op_b[0] ^ carry;
    bit_c = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
  end

  always_comb begin
    b_load = bus.b;
    c_load = bus.ci;
`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: add ~b with an injected carry of 1.
    if (bus.sub) begin
      b_load = ~bus.b;
      c_load = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= b_load;
      carry <= c_load;
      res   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= {1'b0, op_a[WIDTH-1:1]};
      op_b  <= {1'b0, op_b[WIDTH-1:1]};
      res   <= {bit_s, res[WIDTH-1:1]};
      carry <= bit_c;
      if (last) begin
        // Publish includes the bit being computed on this same edge.
        sum_q <= {bit_s, res[WIDTH-1:1]};
        co_q  <= bit_c;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: arithmetic model checked every cycle plus literal expectations per scenario.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request yields {co,sum} = a+b+ci (or a-b), WIDTH edges later.
  int               k;
  int               m_acc_k;
  bit               m_valid;
  bit               m_act;
  bit               m_done;
  logic [WIDTH-1:0] m_sum;
  logic             m_co;
  logic [WIDTH:0]   m_pend;

  initial begin
    k = 0; m_acc_k = 0; m_valid = 0; m_act = 0; m_done = 0;
    m_sum = '0; m_co = 1'b0; m_pend = '0;
  end

  always @(posedge clk) begin
    bit acc;
    k++;
    if (!rst_n) begin
      m_act = 0; m_done = 0; m_sum = '0; m_co = 1'b0; m_valid = 1;
    end else begin
      acc    = bus.start && !m_act;
      m_done = 0;
      if (m_act && k == m_acc_k + WIDTH) begin
        m_act  = 0;
        m_done = 1;
        {m_co, m_sum} = m_pend;
      end
      if (acc) begin
        m_act   = 1;
        m_acc_k = k;
        m_pend  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.ci};
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) m_pend = {(bus.a >= bus.b), bus.a - bus.b};
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", {31'd0, bus.busy}, {31'd0, m_act});
      chk("model_done", {31'd0, bus.done}, {31'd0, m_done});
      chk("model_sum",  {24'd0, bus.sum},  {24'd0, m_sum});
      chk("model_co",   {31'd0, bus.co},   {31'd0, m_co});
    end
  end

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic civ, input logic subv);
    bus.a  = av;
    bus.b  = bv;
    bus.ci = civ;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = subv;
`else
    if (subv) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // Called at a negedge; pulses start for one edge and waits for the done cycle.
  task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic civ, input logic subv,
                        input logic [7:0] exp_sum, input logic exp_co);
    int busy_n;
    bit got;
    drive(av, bv, civ, subv);
    bus.start = 1'b1;
    busy_n = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1;
    end
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({name, "_busy_cycles"}, busy_n, WIDTH);
    chk({name, "_sum"}, {24'd0, bus.sum}, {24'd0, exp_sum});
    chk({name, "_co"}, {31'd0, bus.co}, {31'd0, exp_co});
  endtask

  initial begin
    int  done_n;
    int  busy_n;
    bit  got;
    bit  held_bad;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ci = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum",  {24'd0, bus.sum},  32'd0);
    chk("rst_co",   {31'd0, bus.co},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_3c_47", 8'h3C, 8'h47, 1'b0, 1'b0, 8'h83, 1'b0);
    @(negedge clk);
    run_op("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);

    // Start during RUN must be ignored.
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    bus.start = 1'b1;
    done_n = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 2) begin
        drive(8'h01, 8'h01, 1'b0, 1'b0);
        bus.start = 1'b1;
      end
      if (bus.done) begin
        done_n++;
        if (done_n == 1) chk("ignore_sum", {24'd0, bus.sum}, 32'h30);
      end
    end
    chk("ignore_done_count", done_n, 1);
    chk("ignore_co", {31'd0, bus.co}, 32'd0);

    // Back-to-back: start held in the DONE cycle.
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    bus.start = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) got = 1;
    end
    chk("b2b_first_done", {31'd0, got}, 32'd1);
    chk("b2b_first_sum", {24'd0, bus.sum}, 32'h30);
    drive(8'h80, 8'h80, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_no_idle", {31'd0, bus.busy}, 32'd1);
    busy_n = 1;
    got = 0;
    held_bad = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (bus.sum !== 8'h30) held_bad = 1;
      @(negedge clk);
      if (bus.done) got = 1;
      else if (bus.busy) busy_n++;
    end
    chk("b2b_second_done", {31'd0, got}, 32'd1);
    chk("b2b_run_cycles", busy_n, WIDTH);
    chk("b2b_first_held", {31'd0, held_bad}, 32'd0);
    chk("b2b_sum", {24'd0, bus.sum}, 32'h00);
    chk("b2b_co", {31'd0, bus.co}, 32'd1);
    @(negedge clk);

    // Reset four cycles into a RUN.
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    bus.start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_sum", {24'd0, bus.sum}, 32'd0);
    chk("midrst_co", {31'd0, bus.co}, 32'd0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    chk("midrst_no_done", done_n, 0);
    run_op("after_rst_05_03", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
    run_op("sub0_add", 8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
